// File: rtl/sqrt_axis_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_axis_pkg
// Shared types for the integer sqrt / square self-check stream blocks.
//   ROOT_W     : default root operand width
//   SQ_W       : width of a squared root (2*ROOT_W)
//   sq_state_t : control FSM states of square_axis
//   sq_t       : squared-result word
// -----------------------------------------------------------------------------
package sqrt_axis_pkg;

  localparam int ROOT_W = 16;
  localparam int SQ_W   = 2 * ROOT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  typedef logic [SQ_W-1:0] sq_t;

endpackage : sqrt_axis_pkg

// File: rtl/square_axis_iter.sv
// -----------------------------------------------------------------------------
// square_iter_core
// Radix-2 shift-add squaring datapath. One operand is loaded, then one partial
// product is accumulated per step. The caller runs exactly ROOT_WIDTH steps.
// Ports:
//   clk_i        : clock
//   rst_ni       : async active-low reset, clears all datapath state
//   load_i       : capture root_i and clear the accumulator
//   step_i       : perform one shift-add iteration
//   root_i       : operand to square
//   acc_o        : running / final product (2*ROOT_WIDTH bits)
//   last_step_o  : high while the next step is the final one
// -----------------------------------------------------------------------------
module square_iter_core #(
  parameter int ROOT_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [ROOT_WIDTH-1:0]   root_i,
  output logic [2*ROOT_WIDTH-1:0] acc_o,
  output logic                    last_step_o
);

  localparam int PW    = 2 * ROOT_WIDTH;
  localparam int CNT_W = $clog2(ROOT_WIDTH) + 1;

  logic [PW-1:0]         acc_q,    acc_d;
  logic [PW-1:0]         mcand_q,  mcand_d;
  logic [ROOT_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{ROOT_WIDTH{1'b0}}, root_i};
      mplier_d = root_i;
      cnt_d    = '0;
    end else if (step_i) begin
      // Multiplicand is pre-shifted each step, so bit i of the multiplier
      // always meets mcand << i; the 2*RW accumulator cannot overflow.
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[ROOT_WIDTH-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o       = acc_q;
  assign last_step_o = (cnt_q == CNT_W'(ROOT_WIDTH - 1));

endmodule : square_iter_core

// File: rtl/square_axis.sv
// -----------------------------------------------------------------------------
// square_axis
// AXI-Stream block returning root*root for each unsigned root beat; it follows
// the integer sqrt block in the self-check loop. One beat is squared at a time
// by square_iter_core over ROOT_WIDTH cycles.
// Optional build macro SQUARE_AXIS_SKID_EN adds a one-entry input holding
// register so the next beat is accepted while the current one is in flight.
// Ports:
//   s00_axis_aclk, s00_axis_aresetn : clock, async active-low reset
//   s00_axis_tvalid/tready/tlast    : input handshake and packet end
//   s00_axis_tdata                  : root in [ROOT_WIDTH-1:0], upper bits ignored
//   s00_axis_tstrb                  : ignored
//   m00_axis_tvalid/tready/tlast    : output handshake, tlast of the source beat
//   m00_axis_tdata                  : root^2, zero-extended
//   m00_axis_tstrb                  : all ones
// -----------------------------------------------------------------------------
module square_axis
  import sqrt_axis_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int ROOT_WIDTH             = ROOT_W
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int PW = 2 * ROOT_WIDTH;

  sq_state_t             state_q, state_d;
  logic                  last_q,  last_d;
  logic                  core_load, core_step, core_last_step;
  logic [ROOT_WIDTH-1:0] core_root;
  logic [PW-1:0]         core_acc;
  logic                  s_fire;

  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata};

  assign s_fire = s00_axis_tvalid && s00_axis_tready;

  square_iter_core #(
    .ROOT_WIDTH(ROOT_WIDTH)
  ) u_core (
    .clk_i       (s00_axis_aclk),
    .rst_ni      (s00_axis_aresetn),
    .load_i      (core_load),
    .step_i      (core_step),
    .root_i      (core_root),
    .acc_o       (core_acc),
    .last_step_o (core_last_step)
  );

`ifdef SQUARE_AXIS_SKID_EN
  logic                  hold_full_q, hold_full_d;
  logic [ROOT_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;

  assign s00_axis_tready = !hold_full_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    core_load   = 1'b0;
    core_step   = 1'b0;
    core_root   = s00_axis_tdata[ROOT_WIDTH-1:0];
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    unique case (state_q)
      IDLE: begin
        // DONE only falls back to IDLE with the hold empty, so IDLE always
        // loads straight from the input.
        if (s_fire) begin
          core_load = 1'b1;
          last_d    = s00_axis_tlast;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        core_step = 1'b1;
        if (core_last_step) state_d = DONE;
        if (s_fire) begin
          hold_full_d = 1'b1;
          hold_data_d = s00_axis_tdata[ROOT_WIDTH-1:0];
          hold_last_d = s00_axis_tlast;
        end
      end
      DONE: begin
        if (m00_axis_tready) begin
          if (hold_full_q) begin
            core_load   = 1'b1;
            core_root   = hold_data_q;
            last_d      = hold_last_q;
            hold_full_d = 1'b0;
            state_d     = BUSY;
          end else if (s_fire) begin
            // Beat arriving on the result handshake edge goes straight into
            // the core instead of detouring through the hold.
            core_load = 1'b1;
            last_d    = s00_axis_tlast;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end else if (s_fire) begin
          hold_full_d = 1'b1;
          hold_data_d = s00_axis_tdata[ROOT_WIDTH-1:0];
          hold_last_d = s00_axis_tlast;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      hold_full_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
    end
  end

  // Held payload is qualified by hold_full_q, so it carries no reset.
  always_ff @(posedge s00_axis_aclk) begin
    hold_data_q <= hold_data_d;
    hold_last_q <= hold_last_d;
  end
`else
  assign s00_axis_tready = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    core_load = 1'b0;
    core_step = 1'b0;
    core_root = s00_axis_tdata[ROOT_WIDTH-1:0];
    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          core_load = 1'b1;
          last_d    = s00_axis_tlast;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        core_step = 1'b1;
        if (core_last_step) state_d = DONE;
      end
      DONE: begin
        if (m00_axis_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Output valid comes straight from the state register, never from tready.
  assign m00_axis_tvalid = (state_q == DONE);
  assign m00_axis_tlast  = last_q;
  assign m00_axis_tstrb  = '1;

  always_comb begin
    m00_axis_tdata         = '0;
    m00_axis_tdata[PW-1:0] = core_acc;
  end

endmodule : square_axis

// File: tb/tb_square_axis.sv
module tb_square_axis;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;

  int checks   = 0;
  int failures = 0;

`ifdef SQUARE_AXIS_SKID_EN
  localparam int ACC_GAP = 1;
  localparam int RES_GAP = 17;
`else
  localparam int ACC_GAP = 18;
  localparam int RES_GAP = 18;
`endif

  square_axis dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tready  (s_tready),
    .m00_axis_tready  (m_tready),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && n < 100) begin
      tick();
      n++;
    end
    check("accept_in_time", 64'(n < 100), 64'd1);
    tick();
    s_tvalid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until tvalid rises.
  task automatic wait_result(input string tag, input logic [31:0] exp_d, input logic exp_l);
    int n = 0;
    while (!m_tvalid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd16);
    check({tag, "_tdata"}, 64'(m_tdata), 64'(exp_d));
    check({tag, "_tlast"}, 64'(m_tlast), 64'(exp_l));
  endtask

  logic [31:0] beats  [3];
  logic [31:0] rexp   [3];
  int          acc_cyc[3];
  int          res_cyc[3];

  initial begin
    logic [31:0] x;
    logic        lr;
    int          bi, ri;
    logic        fire;

    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    m_tready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast",  64'(m_tlast),  64'd0);
    check("rst_tdata",  64'(m_tdata),  64'd0);
    check("rst_tready", 64'(s_tready), 64'd1);
    check("tstrb_ones", 64'(m_tstrb),  64'hF);
    rst_n = 1'b1;
    tick();

    // 1: single beat 3 -> 9, one-cycle valid pulse
    send(32'd3, 1'b1);
    wait_result("t1", 32'd9, 1'b1);
    tick();
    check("t1_pulse_1cyc", 64'(m_tvalid), 64'd0);

    // 2: edge operands, upper input bits ignored
    send(32'd0, 1'b0);          wait_result("t2_zero", 32'd0, 1'b0);          tick();
    send(32'd1, 1'b1);          wait_result("t2_one",  32'd1, 1'b1);          tick();
    send(32'h0000_FFFF, 1'b0);  wait_result("t2_max",  32'hFFFE_0001, 1'b0);  tick();
    send(32'h0001_0005, 1'b1);  wait_result("t2_upper", 32'd25, 1'b1);        tick();

    // 3: back-pressure holds the result stable
    m_tready = 1'b0;
    send(32'h0000_1234, 1'b0);
    wait_result("t3", 32'h014B_5A90, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t3_hold", {31'd0, m_tvalid, m_tlast, m_tdata}, {31'd0, 1'b1, 1'b0, 32'h014B_5A90});
`ifndef SQUARE_AXIS_SKID_EN
      check("t3_in_blocked", 64'(s_tready), 64'd0);
`endif
    end
    m_tready = 1'b1;
    tick();
    check("t3_released", 64'(m_tvalid), 64'd0);

    // 4: reset in BUSY drops the beat
    send(32'h0000_ABCD, 1'b1);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("t4_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t4_rst_tdata",  64'(m_tdata),  64'd0);
    check("t4_rst_tlast",  64'(m_tlast),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t4_no_stale", 64'(m_tvalid), 64'd0);
    send(32'd10, 1'b1);
    wait_result("t4_after", 32'd100, 1'b1);
    tick();

    // 5: continuous input stream, accept and result spacing
    beats[0] = 32'd2;  beats[1] = 32'd5;  beats[2] = 32'd7;
    rexp[0]  = 32'd4;  rexp[1]  = 32'd25; rexp[2]  = 32'd49;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = 0; res_cyc[i] = 0; end
    bi = 0; ri = 0;
    s_tdata = beats[0]; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
    for (int cyc = 0; cyc < 200 && ri < 3; cyc++) begin
      fire = s_tvalid && s_tready;
      tick();
      if (fire) begin
        acc_cyc[bi] = cyc;
        bi++;
        if (bi < 3) s_tdata = beats[bi];
        else        s_tvalid = 1'b0;
        s_tlast = (bi == 2);
      end
      if (m_tvalid) begin
        check("t5_tdata", 64'(m_tdata), 64'(rexp[ri]));
        check("t5_tlast", 64'(m_tlast), 64'(ri == 2));
        res_cyc[ri] = cyc;
        ri++;
      end
    end
    s_tvalid = 1'b0;
    check("t5_result_count", 64'(ri), 64'd3);
    check("t5_first_latency", 64'(res_cyc[0] - acc_cyc[0]), 64'd16);
    check("t5_accept_gap",    64'(acc_cyc[1] - acc_cyc[0]), 64'(ACC_GAP));
    check("t5_result_gap01",  64'(res_cyc[1] - res_cyc[0]), 64'(RES_GAP));
    check("t5_result_gap12",  64'(res_cyc[2] - res_cyc[1]), 64'(RES_GAP));
    tick();

    // 6: random roots against an independent product
    for (int i = 0; i < 6; i++) begin
      x  = $urandom;
      lr = 1'(x[31] ^ x[7]);
      send(x, lr);
      wait_result("t6_rand", {16'd0, x[15:0]} * {16'd0, x[15:0]}, lr);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_square_axis
